// File: rtl/mpe_result_packer.sv
// Packs matrix_pe dot-product results into 512-bit lines and queues them for the NRAM write port.
// Optional MPE_PACK_RELU_EN: clamp negative (signed) results to zero before packing.
module mpe_result_packer #(
    parameter int DATA_W     = 32,
    parameter int LANES      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         pe_result,
    input  logic                      pe_vld_i,
    input  logic                      flush,
    output logic [DATA_W*LANES-1:0]   nram_line,
    output logic [LANES-1:0]          nram_lane_mask,
    output logic                      nram_valid,
    input  logic                      nram_ready,
    output logic                      overflow,
    output logic                      busy
);

    localparam int LINE_W = DATA_W * LANES;
    localparam int LANE_W = $clog2(LANES);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef logic [LANES-1:0][DATA_W-1:0] pack_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] word_in;

    always_comb begin
`ifdef MPE_PACK_RELU_EN
        word_in = pe_result[DATA_W-1] ? '0 : pe_result;
`else
        word_in = pe_result;
`endif
    end

    // ------------------------------------------------------------------
    // Line packing
    // ------------------------------------------------------------------
    logic [LANE_W-1:0] lane_ptr_q, lane_ptr_d;
    pack_t             pack_q, pack_d;
    logic [LANES-1:0]  mask_q, mask_d;

    logic              line_done;
    logic              push_req;
    pack_t             push_line;
    logic [LANES-1:0]  push_mask;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pack_d     = pack_q;
        mask_d     = mask_q;
        lane_ptr_d = lane_ptr_q;

        if (pe_vld_i) begin
            pack_d[lane_ptr_q] = word_in;
            mask_d[lane_ptr_q] = 1'b1;
            lane_ptr_d         = lane_ptr_q + LANE_W'(1);
        end

        line_done = pe_vld_i && (lane_ptr_q == LAST_LANE);
        push_req  = line_done || (flush && (pe_vld_i || (lane_ptr_q != '0)));

        // The pushed line includes any word arriving this cycle.
        push_line = pack_d;
        push_mask = mask_d;

        if (push_req) begin
            pack_d     = '0;
            mask_d     = '0;
            lane_ptr_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_ptr_q <= '0;
            pack_q     <= '0;
            mask_q     <= '0;
        end else begin
            lane_ptr_q <= lane_ptr_d;
            pack_q     <= pack_d;
            mask_q     <= mask_d;
        end
    end

    // ------------------------------------------------------------------
    // Packed-line FIFO
    // ------------------------------------------------------------------
    logic [LINE_W-1:0] line_mem_q [FIFO_DEPTH];
    logic [LANES-1:0]  mask_mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;

    logic              fifo_full;
    logic              pop;
    logic              push_ok;
    logic              drop;

    always_comb begin
        fifo_full = (count_q == DEPTH_C);
        pop       = (count_q != '0) && nram_ready;
        // A full FIFO still accepts a line when the head leaves in the same cycle.
        push_ok   = push_req && (!fifo_full || pop);
        drop      = push_req && fifo_full && !pop;

        wr_ptr_d   = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        overflow_d = overflow_q | drop;

        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is not reset; clearing the pointers empties the FIFO and the outputs are
    // gated by valid, so stale entries are never observable.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            line_mem_q[wr_ptr_q] <= push_line;
            mask_mem_q[wr_ptr_q] <= push_mask;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        nram_valid     = (count_q != '0);
        nram_line      = nram_valid ? line_mem_q[rd_ptr_q] : '0;
        nram_lane_mask = nram_valid ? mask_mem_q[rd_ptr_q] : '0;
        overflow       = overflow_q;
        busy           = (lane_ptr_q != '0) || nram_valid;
    end

endmodule

// File: tb/tb_mpe_result_packer.sv
// Directed bench for mpe_result_packer: vector table plus hand-written stall/overflow sequences.
module tb_mpe_result_packer;

    localparam int DATA_W     = 32;
    localparam int LANES      = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int LW         = DATA_W * LANES;

`ifdef MPE_PACK_RELU_EN
    localparam logic [31:0] NEG_EXP = 32'h0000_0000;
`else
    localparam logic [31:0] NEG_EXP = 32'hFFFF_FFF6;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] pe_result = '0;
    logic              pe_vld_i = 1'b0;
    logic              flush = 1'b0;
    logic [LW-1:0]     nram_line;
    logic [LANES-1:0]  nram_lane_mask;
    logic              nram_valid;
    logic              nram_ready = 1'b1;
    logic              overflow;
    logic              busy;

    always #5 clk = ~clk;

    mpe_result_packer #(
        .DATA_W     (DATA_W),
        .LANES      (LANES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pe_result      (pe_result),
        .pe_vld_i       (pe_vld_i),
        .flush          (flush),
        .nram_line      (nram_line),
        .nram_lane_mask (nram_lane_mask),
        .nram_valid     (nram_valid),
        .nram_ready     (nram_ready),
        .overflow       (overflow),
        .busy           (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] line_of(input logic [31:0] base);
        logic [LW-1:0] l;
        l = '0;
        for (int k = 0; k < LANES; k++) l[32*k +: 32] = base + 32'(k);
        return l;
    endfunction

    task automatic drive(input logic vld, input logic fl, input logic [31:0] d);
        pe_vld_i  = vld;
        flush     = fl;
        pe_result = d;
        @(posedge clk);
        #1;
        pe_vld_i  = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        vld;
        logic        fl;
        logic [31:0] data;
        logic        exp_valid;
        logic [15:0] exp_mask;
        logic [31:0] exp_l0;
        logic [31:0] exp_l3;
        logic [31:0] exp_l4;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [16];

    int            got;
    int            s;
    logic          hold;
    logic          rdy;
    logic [LW-1:0] held_line;
    logic [15:0]   held_mask;

    initial begin
        // vld  fl    data            valid mask      l0              l3              l4              busy
        vecs[0]  = '{1'b1, 1'b0, 32'hA000_0000, 1'b0, 16'h0000, 32'h0,          32'h0,          32'h0,          1'b1};
        vecs[1]  = '{1'b1, 1'b0, 32'hA000_0001, 1'b0, 16'h0000, 32'h0,          32'h0,          32'h0,          1'b1};
        vecs[2]  = '{1'b1, 1'b0, 32'hA000_0002, 1'b0, 16'h0000, 32'h0,          32'h0,          32'h0,          1'b1};
        vecs[3]  = '{1'b1, 1'b0, 32'hA000_0003, 1'b0, 16'h0000, 32'h0,          32'h0,          32'h0,          1'b1};
        vecs[4]  = '{1'b1, 1'b0, 32'hA000_0004, 1'b0, 16'h0000, 32'h0,          32'h0,          32'h0,          1'b1};
        vecs[5]  = '{1'b0, 1'b1, 32'h0,         1'b1, 16'h001F, 32'hA000_0000, 32'hA000_0003, 32'hA000_0004, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b0, 16'h0000, 32'h0,          32'h0,          32'h0,          1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h0,         1'b0, 16'h0000, 32'h0,          32'h0,          32'h0,          1'b0};
        vecs[8]  = '{1'b1, 1'b1, 32'hB000_0000, 1'b1, 16'h0001, 32'hB000_0000, 32'h0,          32'h0,          1'b1};
        vecs[9]  = '{1'b1, 1'b0, 32'hC000_0000, 1'b0, 16'h0000, 32'h0,          32'h0,          32'h0,          1'b1};
        vecs[10] = '{1'b1, 1'b0, 32'hC000_0001, 1'b0, 16'h0000, 32'h0,          32'h0,          32'h0,          1'b1};
        vecs[11] = '{1'b1, 1'b0, 32'hC000_0002, 1'b0, 16'h0000, 32'h0,          32'h0,          32'h0,          1'b1};
        vecs[12] = '{1'b1, 1'b1, 32'hC000_0003, 1'b1, 16'h000F, 32'hC000_0000, 32'hC000_0003, 32'h0,          1'b1};
        vecs[13] = '{1'b1, 1'b1, 32'hFFFF_FFF6, 1'b1, 16'h0001, NEG_EXP,        32'h0,          32'h0,          1'b1};
        vecs[14] = '{1'b1, 1'b1, 32'h0000_000A, 1'b1, 16'h0001, 32'h0000_000A, 32'h0,          32'h0,          1'b1};
        vecs[15] = '{1'b0, 1'b0, 32'h0,         1'b0, 16'h0000, 32'h0,          32'h0,          32'h0,          1'b0};

        // Reset state
        rst = 1'b1;
        @(posedge clk);
        do_reset();
        check("rst_valid",    LW'(nram_valid), LW'(0));
        check("rst_line",     nram_line, '0);
        check("rst_mask",     LW'(nram_lane_mask), LW'(0));
        check("rst_overflow", LW'(overflow), LW'(0));
        check("rst_busy",     LW'(busy), LW'(0));

        // Table: partial lines, flush corner cases, ReLU, back-to-back pushes
        nram_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].vld, vecs[i].fl, vecs[i].data);
            check($sformatf("vec%0d_valid", i), LW'(nram_valid), LW'(vecs[i].exp_valid));
            check($sformatf("vec%0d_busy", i),  LW'(busy),       LW'(vecs[i].exp_busy));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_mask", i), LW'(nram_lane_mask), LW'(vecs[i].exp_mask));
                check($sformatf("vec%0d_l0", i),   LW'(nram_line[31:0]),    LW'(vecs[i].exp_l0));
                check($sformatf("vec%0d_l3", i),   LW'(nram_line[127:96]),  LW'(vecs[i].exp_l3));
                check($sformatf("vec%0d_l4", i),   LW'(nram_line[159:128]), LW'(vecs[i].exp_l4));
            end
        end

        // Full line of 1..16, valid for exactly one cycle after the 16th strobe
        for (int k = 0; k < LANES; k++) begin
            drive(1'b1, 1'b0, 32'(k + 1));
            if (k < LANES - 1) check($sformatf("s1_early_valid%0d", k), LW'(nram_valid), LW'(0));
        end
        check("s1_valid", LW'(nram_valid), LW'(1));
        check("s1_mask",  LW'(nram_lane_mask), LW'(16'hFFFF));
        for (int k = 0; k < LANES; k++)
            check($sformatf("s1_lane%0d", k), LW'(nram_line[32*k +: 32]), LW'(32'(k + 1)));
        drive(1'b0, 1'b0, 32'h0);
        check("s1_valid_after", LW'(nram_valid), LW'(0));
        check("s1_busy_after",  LW'(busy), LW'(0));

        // Stall: 5 lines with nram_ready=0, the 5th is dropped
        nram_ready = 1'b0;
        for (int l = 0; l < 5; l++) begin
            for (int k = 0; k < LANES; k++) begin
                drive(1'b1, 1'b0, 32'(l * 16 + k + 1));
                if (l == 3 && k == 15) check("s2_ovf_before", LW'(overflow), LW'(0));
                if (l > 0 && k == 7)   check($sformatf("s2_head_hold%0d", l), nram_line, line_of(32'd1));
            end
        end
        check("s2_ovf",   LW'(overflow), LW'(1));
        check("s2_valid", LW'(nram_valid), LW'(1));
        check("s2_busy",  LW'(busy), LW'(1));
        nram_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            if (!nram_valid) break;
            check($sformatf("s2_drain%0d", got), nram_line, line_of(32'(got * 16 + 1)));
            got++;
            drive(1'b0, 1'b0, 32'h0);
        end
        check("s2_lines", LW'(got), LW'(4));
        check("s2_busy_end", LW'(busy), LW'(0));
        check("s2_ovf_sticky", LW'(overflow), LW'(1));

        // Reset mid-operation discards partial and queued data and clears overflow
        nram_ready = 1'b0;
        for (int k = 0; k < 19; k++) drive(1'b1, 1'b0, 32'hDEAD_0000 + 32'(k));
        do_reset();
        check("mid_rst_valid", LW'(nram_valid), LW'(0));
        check("mid_rst_line",  nram_line, '0);
        check("mid_rst_mask",  LW'(nram_lane_mask), LW'(0));
        check("mid_rst_ovf",   LW'(overflow), LW'(0));
        check("mid_rst_busy",  LW'(busy), LW'(0));

        // Full FIFO, 16th strobe of the 5th line coincides with a pop
        nram_ready = 1'b0;
        for (int l = 0; l < 5; l++) begin
            for (int k = 0; k < LANES; k++) begin
                if (l == 4 && k == 15) nram_ready = 1'b1;
                drive(1'b1, 1'b0, 32'(l * 16 + k + 1));
            end
        end
        check("s3_ovf", LW'(overflow), LW'(0));
        got = 1;
        for (int c = 0; c < 10; c++) begin
            if (!nram_valid) break;
            check($sformatf("s3_drain%0d", got), nram_line, line_of(32'(got * 16 + 1)));
            got++;
            drive(1'b0, 1'b0, 32'h0);
        end
        check("s3_lines", LW'(got), LW'(5));
        check("s3_busy_end", LW'(busy), LW'(0));
        check("s3_ovf_end", LW'(overflow), LW'(0));

        // Random nram_ready gaps with back-to-back strobes
        s    = 0;
        got  = 0;
        hold = 1'b0;
        held_line = '0;
        held_mask = '0;
        for (int c = 0; c < 600 && got < 6; c++) begin
            if (hold) begin
                check("s4_hold_valid", LW'(nram_valid), LW'(1));
                check("s4_hold_line",  nram_line, held_line);
                check("s4_hold_mask",  LW'(nram_lane_mask), LW'(held_mask));
            end
            rdy = ($urandom_range(0, 3) != 0);
            nram_ready = rdy;
            if (nram_valid && rdy) begin
                check($sformatf("s4_line%0d", got), nram_line, line_of(32'h1000 + 32'(got * 16)));
                check($sformatf("s4_mask%0d", got), LW'(nram_lane_mask), LW'(16'hFFFF));
                got++;
                hold = 1'b0;
            end else begin
                hold = nram_valid;
            end
            held_line = nram_line;
            held_mask = nram_lane_mask;
            if (s < 96) begin
                pe_vld_i  = 1'b1;
                pe_result = 32'h1000 + 32'(s);
                s++;
            end
            @(posedge clk);
            #1;
            pe_vld_i = 1'b0;
        end
        check("s4_lines", LW'(got), LW'(6));
        check("s4_ovf",   LW'(overflow), LW'(0));
        check("s4_busy",  LW'(busy), LW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
